mem_line_bridge: RTL

MEM_LINE_BRIDGE -- requirements
Module: mem_line_bridge

---
 rtl/mem_line_bridge.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_line_bridge.sv
// Purpose : bridges one line-wide memory request (LINE_WORDS x 32 bit) onto a word-wide generic bus master.
// Latency : read accept-to-mem_rsp_valid = LINE_WORDS+1 cycles plus one cycle per stalled bus cycle; writes return to IDLE after the same count.
// Backpr. : mem_req_ready only in IDLE; bus_request_stall freezes the current word; response held until mem_rsp_ready.
//
// Ports   : clk/nRST (async active-low reset)
//           mem_req_*  line request in (valid/ready), mem_rsp_* line response out (valid/ready), busy = transaction in flight
//           bus_*      word bus master: addr/ren/wen/wdata/strobe out, rdata/request_stall in
// Option  : `define MEM_LINE_BRIDGE_SKIP_EMPTY_EN to skip write words whose byte-enable slice is all zero (no bus cycle).
module mem_line_bridge #(
    parameter int LINE_WORDS = 16,
    parameter int ADDR_WIDTH = 26,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       nRST,
    input  logic                       mem_req_valid,
    input  logic                       mem_req_rw,
    input  logic [LINE_WORDS*4-1:0]    mem_req_byteen,
    input  logic [ADDR_WIDTH-1:0]      mem_req_addr,
    input  logic [LINE_WORDS*32-1:0]   mem_req_data,
    input  logic [TAG_WIDTH-1:0]       mem_req_tag,
    output logic                       mem_req_ready,
    output logic                       mem_rsp_valid,
    output logic [LINE_WORDS*32-1:0]   mem_rsp_data,
    output logic [TAG_WIDTH-1:0]       mem_rsp_tag,
    input  logic                       mem_rsp_ready,
    output logic                       busy,
    output logic [31:0]                bus_addr,
    output logic                       bus_ren,
    output logic                       bus_wen,
    output logic [31:0]                bus_wdata,
    output logic [3:0]                 bus_strobe,
    input  logic [31:0]                bus_rdata,
    input  logic                       bus_request_stall
);

    localparam int IDX_W  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int FULL_W = ADDR_WIDTH + IDX_W + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                     r_state;
    logic [IDX_W-1:0]           r_idx;
    logic                       r_rw;
    logic [LINE_WORDS*4-1:0]    r_byteen;
    logic [ADDR_WIDTH-1:0]      r_addr;
    logic [LINE_WORDS*32-1:0]   r_data;
    logic [TAG_WIDTH-1:0]       r_tag;
    logic [LINE_WORDS*32-1:0]   r_line;

    logic                       w_access;
    logic                       w_skip;
    logic                       w_step;
    logic                       w_last;
    logic [3:0]                 w_strobe;
    logic [FULL_W-1:0]          w_full_addr;

    assign w_access    = (r_state == ACCESS);
    assign w_strobe    = r_byteen[4*r_idx +: 4];
    assign w_last      = (r_idx == LAST_IDX);
    assign w_full_addr = {r_addr, r_idx, 2'b00};

`ifdef MEM_LINE_BRIDGE_SKIP_EMPTY_EN
    // An empty write word costs one clock but never reaches the bus, so the stall input is irrelevant for it.
    assign w_skip = r_rw && (w_strobe == 4'b0000);
`else
    assign w_skip = 1'b0;
`endif

    // A word retires on any ACCESS cycle the bus does not stall (or that is skipped outright).
    assign w_step = w_access && (!bus_request_stall || w_skip);

    // Byte address is the line address concatenated with the word index, fitted to the 32-bit bus.
    generate
        if (FULL_W >= 32) begin : g_addr_trunc
            assign bus_addr = w_full_addr[31:0];
        end else begin : g_addr_ext
            assign bus_addr = {{(32-FULL_W){1'b0}}, w_full_addr};
        end
    endgenerate

    // All bus outputs decode only registered state, so they stay frozen while the bus stalls.
    assign bus_ren    = w_access && !r_rw;
    assign bus_wen    = w_access && r_rw && !w_skip;
    assign bus_wdata  = r_data[32*r_idx +: 32];
    assign bus_strobe = w_strobe;

    assign mem_req_ready = (r_state == IDLE);
    assign mem_rsp_valid = (r_state == RESP);
    assign mem_rsp_data  = r_line;
    assign mem_rsp_tag   = r_tag;
    assign busy          = (r_state != IDLE);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_rw     <= 1'b0;
            r_byteen <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_tag    <= '0;
            r_line   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mem_req_valid) begin
                        r_rw     <= mem_req_rw;
                        r_byteen <= mem_req_byteen;
                        r_addr   <= mem_req_addr;
                        r_data   <= mem_req_data;
                        r_tag    <= mem_req_tag;
                        r_idx    <= '0;
                        r_state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (w_step) begin
                        if (!r_rw) begin
                            r_line[32*r_idx +: 32] <= bus_rdata;
                        end
                        if (w_last) begin
                            r_idx   <= '0;
                            // Writes are posted: no response phase.
                            r_state <= r_rw ? IDLE : RESP;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                RESP: begin
                    if (mem_rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
